orv64_pmp_req_stage: RTL and testbench

- Two-entry request pipeline between the PTW/TLB physical-address output and the PMP check logic.
- Registers each translated request (S1) and drives the combinational PMP check port from S1.
- Captures the verdict into a result register (S2) and hands it to the LSU/IFU consumer over valid/ready.
- Also handles flush, PMP-CSR-write interlock and a saturating fault counter.

---
 rtl/orv64_typedef_pkg.sv | 35 +++
 rtl/orv64_sat_cnt.sv | 23 ++
 rtl/orv64_pmp_req_stage.sv | 91 +++++++++
 tb/tb_orv64_pmp_req_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/orv64_typedef_pkg.sv
// orv64_typedef_pkg: shared ORV64 address/access/exception types and PMP request-stage payloads.
package orv64_typedef_pkg;

    typedef logic [55:0] orv64_paddr_t;

    typedef enum logic [1:0] {
        ORV64_ACCESS_FETCH = 2'd0,
        ORV64_ACCESS_LOAD  = 2'd1,
        ORV64_ACCESS_STORE = 2'd2
    } orv64_access_type_t;

    typedef logic [3:0] orv64_excp_cause_t;
    typedef logic [3:0] cpu_byte_mask_t;

    localparam orv64_excp_cause_t ORV64_EXCP_INST_ACCESS_FAULT  = 4'd1;
    localparam orv64_excp_cause_t ORV64_EXCP_LOAD_ACCESS_FAULT  = 4'd5;
    localparam orv64_excp_cause_t ORV64_EXCP_STORE_ACCESS_FAULT = 4'd7;

    localparam int ORV64_PMP_TAG_W = 4;

    typedef struct packed {
        orv64_paddr_t                paddr;
        orv64_access_type_t          access_type;
        cpu_byte_mask_t              byte_width;
        logic [ORV64_PMP_TAG_W-1:0]  tag;
    } orv64_pmp_req_t;

    typedef struct packed {
        orv64_paddr_t                paddr;
        logic [ORV64_PMP_TAG_W-1:0]  tag;
        logic                        excp_valid;
        orv64_excp_cause_t           excp_cause;
    } orv64_pmp_resp_t;

endpackage

// File: rtl/orv64_sat_cnt.sv
// orv64_sat_cnt: saturating up-counter with synchronous clear, shared by perf/fault counters.
module orv64_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i)
            cnt_q <= '0;
        else if (inc_i && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/orv64_pmp_req_stage.sv
// orv64_pmp_req_stage: two-entry PTW/TLB -> PMP -> LSU/IFU pipeline with flush,
// PMP-CSR-write interlock and a saturating fault counter.
module orv64_pmp_req_stage
    import orv64_typedef_pkg::*;
#(
    parameter int TAG_W = ORV64_PMP_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               csr_pmp_wr_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  orv64_paddr_t       req_paddr_i,
    input  orv64_access_type_t req_access_type_i,
    input  cpu_byte_mask_t     req_byte_width_i,
    input  logic [TAG_W-1:0]   req_tag_i,
    output logic               chk_paddr_valid_o,
    output orv64_paddr_t       chk_paddr_o,
    output orv64_access_type_t chk_access_type_o,
    output cpu_byte_mask_t     chk_byte_width_o,
    input  logic               chk_excp_valid_i,
    input  orv64_excp_cause_t  chk_excp_cause_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output orv64_paddr_t       resp_paddr_o,
    output logic [TAG_W-1:0]   resp_tag_o,
    output logic               resp_excp_valid_o,
    output orv64_excp_cause_t  resp_excp_cause_o,
    output logic [CNT_W-1:0]   fault_cnt_o
);

    orv64_pmp_req_t  s1_q, s1_d;
    orv64_pmp_resp_t s2_q, s2_d;
    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;
    logic            hold_q;
    logic            s2_free, s1_adv, accept, fault_inc;

    // hold_q blocks S1 for the cycle after a CSR write so the checker sees the new PMP state
    always_comb begin
        s2_free     = ~s2_valid_q | resp_ready_i;
        s1_adv      = s1_valid_q & s2_free & ~csr_pmp_wr_i & ~hold_q & ~flush_i;
        req_ready_o = (~s1_valid_q | s1_adv) & ~flush_i & ~csr_pmp_wr_i;
        accept      = req_valid_i & req_ready_o;
        s1_valid_d  = ~flush_i & (accept | (s1_valid_q & ~s1_adv));
        s2_valid_d  = ~flush_i & (s1_adv | (s2_valid_q & ~resp_ready_i));
        fault_inc   = s2_valid_q & resp_ready_i & s2_q.excp_valid & ~flush_i;
        s1_d        = accept ? '{paddr: req_paddr_i, access_type: req_access_type_i,
                                 byte_width: req_byte_width_i, tag: req_tag_i} : s1_q;
        s2_d        = s1_adv ? '{paddr: s1_q.paddr, tag: s1_q.tag, excp_valid: chk_excp_valid_i,
                                 excp_cause: chk_excp_valid_i ? chk_excp_cause_i : '0} : s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            hold_q     <= csr_pmp_wr_i;
        end
    end

    always_ff @(posedge clk) begin
        s1_q <= s1_d;
        s2_q <= s2_d;
    end

    orv64_sat_cnt #(.W(CNT_W)) u_fault_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (fault_inc),
        .cnt_o (fault_cnt_o)
    );

    assign chk_paddr_valid_o = s1_valid_q & ~flush_i;
    assign chk_paddr_o       = s1_q.paddr;
    assign chk_access_type_o = s1_q.access_type;
    assign chk_byte_width_o  = s1_q.byte_width;
    assign resp_valid_o      = s2_valid_q;
    assign resp_paddr_o      = s2_q.paddr;
    assign resp_tag_o        = s2_q.tag;
    assign resp_excp_valid_o = s2_valid_q & s2_q.excp_valid;
    assign resp_excp_cause_o = s2_q.excp_cause;

endmodule

// File: tb/tb_orv64_pmp_req_stage.sv
// tb_orv64_pmp_req_stage: directed-vector bench for the PMP request stage (2-bit fault counter).
module tb_orv64_pmp_req_stage;
    import orv64_typedef_pkg::*;

    logic               clk = 1'b0;
    logic               rst, flush, csr_wr, req_valid, req_ready, resp_ready;
    orv64_paddr_t       req_paddr, chk_paddr, resp_paddr;
    orv64_access_type_t req_type, chk_type;
    cpu_byte_mask_t     req_bw, chk_bw;
    logic [3:0]         req_tag, resp_tag;
    logic               chk_pv, chk_ev, resp_valid, resp_ev;
    orv64_excp_cause_t  chk_cause, resp_cause;
    logic [1:0]         fault_cnt;
    int                 n_vec = 0;
    int                 n_err = 0;

    always #5 clk = ~clk;

    orv64_pmp_req_stage #(.TAG_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .flush_i(flush), .csr_pmp_wr_i(csr_wr),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_paddr_i(req_paddr),
        .req_access_type_i(req_type), .req_byte_width_i(req_bw), .req_tag_i(req_tag),
        .chk_paddr_valid_o(chk_pv), .chk_paddr_o(chk_paddr), .chk_access_type_o(chk_type),
        .chk_byte_width_o(chk_bw), .chk_excp_valid_i(chk_ev), .chk_excp_cause_i(chk_cause),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_paddr_o(resp_paddr),
        .resp_tag_o(resp_tag), .resp_excp_valid_o(resp_ev), .resp_excp_cause_o(resp_cause),
        .fault_cnt_o(fault_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [3:0] t, input logic [55:0] a, input orv64_access_type_t ty);
        req_valid = v;
        req_tag   = t;
        req_paddr = a;
        req_type  = ty;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; csr_wr = 1'b0; resp_ready = 1'b1;
        chk_ev = 1'b0; chk_cause = '0; req_bw = 4'd8;
        offer(1'b0, 4'd0, 56'h0, ORV64_ACCESS_LOAD);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_ev", resp_ev, 0);
        chk("rst_fault_cnt", fault_cnt, 0);
        chk("rst_chk_pv", chk_pv, 0);

        // single load
        offer(1'b1, 4'd1, 56'h8000_1000, ORV64_ACCESS_LOAD);
        #1 chk("t1_req_ready", req_ready, 1);
        cyc();
        offer(1'b0, 4'd0, 56'h0, ORV64_ACCESS_LOAD);
        #1 chk("t1_chk_pv", chk_pv, 1);
        chk("t1_chk_paddr", chk_paddr, 56'h8000_1000);
        chk("t1_chk_type", chk_type, ORV64_ACCESS_LOAD);
        chk("t1_resp_valid_early", resp_valid, 0);
        cyc();
        #1 chk("t1_resp_valid", resp_valid, 1);
        chk("t1_resp_paddr", resp_paddr, 56'h8000_1000);
        chk("t1_resp_tag", resp_tag, 1);
        chk("t1_resp_ev", resp_ev, 0);
        cyc();
        #1 chk("t1_drained", resp_valid, 0);
        chk("t1_fault_cnt", fault_cnt, 0);

        // back-to-back 8 requests
        for (int i = 0; i < 10; i++) begin
            offer(i < 8, 4'(i), 56'h1000 + 56'(i * 8), ORV64_ACCESS_LOAD);
            #1;
            if (i < 8) chk("t2_req_ready", req_ready, 1);
            if (i >= 2) begin
                chk("t2_resp_valid", resp_valid, 1);
                chk("t2_resp_tag", resp_tag, 64'(i - 2));
                chk("t2_resp_paddr", resp_paddr, 56'h1000 + 56'((i - 2) * 8));
            end
            cyc();
        end
        #1 chk("t2_drained", resp_valid, 0);

        // store fault with backpressure
        resp_ready = 1'b0; chk_ev = 1'b1; chk_cause = ORV64_EXCP_STORE_ACCESS_FAULT;
        offer(1'b1, 4'd3, 56'h2000, ORV64_ACCESS_STORE);
        cyc();
        offer(1'b0, 4'd0, 56'h0, ORV64_ACCESS_LOAD);
        #1 chk("t3_chk_type", chk_type, ORV64_ACCESS_STORE);
        cyc();
        offer(1'b1, 4'd4, 56'h2008, ORV64_ACCESS_STORE);
        #1 chk("t3_req_ready_s1_free", req_ready, 1);
        chk("t3_resp_valid", resp_valid, 1);
        chk("t3_resp_ev", resp_ev, 1);
        chk("t3_resp_cause", resp_cause, 7);
        cyc();
        for (int i = 0; i < 5; i++) begin
            offer(1'b1, 4'd5, 56'h2010, ORV64_ACCESS_STORE);
            #1 chk("t3_stall_req_ready", req_ready, 0);
            chk("t3_stall_resp_valid", resp_valid, 1);
            chk("t3_stall_tag", resp_tag, 3);
            chk("t3_stall_paddr", resp_paddr, 56'h2000);
            chk("t3_stall_cause", resp_cause, 7);
            chk("t3_stall_cnt", fault_cnt, 0);
            cyc();
        end
        offer(1'b0, 4'd0, 56'h0, ORV64_ACCESS_LOAD);
        resp_ready = 1'b1;
        cyc();
        #1 chk("t3_fault_cnt1", fault_cnt, 1);
        chk("t3_next_tag", resp_tag, 4);
        chk("t3_next_ev", resp_ev, 1);
        chk_ev = 1'b0;
        cyc();
        #1 chk("t3_fault_cnt2", fault_cnt, 2);
        chk("t3_drained", resp_valid, 0);

        // CSR write interlock
        offer(1'b1, 4'd6, 56'h3000, ORV64_ACCESS_LOAD);
        cyc();
        offer(1'b1, 4'd7, 56'h3008, ORV64_ACCESS_LOAD);
        csr_wr = 1'b1;
        #1 chk("t4_csr_req_ready", req_ready, 0);
        chk("t4_csr_chk_pv", chk_pv, 1);
        cyc();
        csr_wr = 1'b0; chk_ev = 1'b1; chk_cause = ORV64_EXCP_INST_ACCESS_FAULT;
        #1 chk("t4_hold_req_ready", req_ready, 0);
        chk("t4_hold_resp_valid", resp_valid, 0);
        cyc();
        chk_cause = ORV64_EXCP_LOAD_ACCESS_FAULT;
        #1 chk("t4_adv_req_ready", req_ready, 1);
        chk("t4_adv_resp_valid", resp_valid, 0);
        cyc();
        offer(1'b0, 4'd0, 56'h0, ORV64_ACCESS_LOAD);
        chk_ev = 1'b0;
        #1 chk("t4_resp_tag", resp_tag, 6);
        chk("t4_resp_ev", resp_ev, 1);
        chk("t4_resp_cause", resp_cause, 5);
        cyc();
        #1 chk("t4_tag7", resp_tag, 7);
        chk("t4_tag7_ev", resp_ev, 0);
        chk("t4_tag7_cause_zero", resp_cause, 0);
        chk("t4_fault_cnt", fault_cnt, 3);
        cyc();

        // saturation, then mid-operation reset
        rst = 1'b1;
        cyc();
        rst = 1'b0; chk_ev = 1'b1; chk_cause = ORV64_EXCP_LOAD_ACCESS_FAULT;
        for (int k = 0; k < 8; k++) begin
            offer(1'b1, 4'(k), 56'h4000 + 56'(k * 8), ORV64_ACCESS_LOAD);
            #1;
            if (k == 0) chk("t6_cnt_after_rst", fault_cnt, 0);
            if (k >= 3) chk("t6_sat_cnt", fault_cnt, 64'((k - 2 > 3) ? 3 : k - 2));
            cyc();
        end
        offer(1'b0, 4'd0, 56'h0, ORV64_ACCESS_LOAD);
        #1 chk("t6_busy", resp_valid, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1 chk("t6_rst_cnt", fault_cnt, 0);
        chk("t6_rst_resp_valid", resp_valid, 0);
        chk("t6_rst_chk_pv", chk_pv, 0);

        // flush with both stages full
        resp_ready = 1'b0; chk_cause = ORV64_EXCP_STORE_ACCESS_FAULT;
        offer(1'b1, 4'd8, 56'h5000, ORV64_ACCESS_STORE);
        cyc();
        offer(1'b1, 4'd9, 56'h5008, ORV64_ACCESS_STORE);
        cyc();
        offer(1'b1, 4'd10, 56'h5010, ORV64_ACCESS_STORE);
        #1 chk("t5_full_resp_valid", resp_valid, 1);
        chk("t5_full_chk_pv", chk_pv, 1);
        flush = 1'b1; resp_ready = 1'b1;
        #1 chk("t5_flush_req_ready", req_ready, 0);
        chk("t5_flush_chk_pv", chk_pv, 0);
        cyc();
        flush = 1'b0;
        offer(1'b0, 4'd0, 56'h0, ORV64_ACCESS_LOAD);
        #1 chk("t5_resp_valid", resp_valid, 0);
        chk("t5_chk_pv", chk_pv, 0);
        chk("t5_fault_cnt", fault_cnt, 0);
        cyc();
        #1 chk("t5_still_empty", resp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
